// File: rtl/run_length_packer.sv
// run_length_packer: encodes a 1-bit stream into (bit, length) runs
// and buffers finished runs in a small FIFO with a valid/ready head.
module run_length_packer #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         x,
   input  logic                         en,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_bit,
   output logic [CNT_W-1:0]             out_len,
   output logic [$clog2(DEPTH+1)-1:0]   out_count,
   output logic                         ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_n;
   logic               cur_bit, bit_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic               push, push_bit;
   logic [CNT_W-1:0]   push_len;

   logic [CNT_W:0]     mem [DEPTH];
   logic [PW-1:0]      rd_ptr, wr_ptr, rd_n;
   logic [OW-1:0]      count, count_n;
   logic               pop, full, acc;
   logic [CNT_W:0]     head_n;

   // Run state register: open run value and length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cur_bit <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         cur_bit <= bit_n;
         cnt     <= cnt_n;
      end
   end

   // Next run state; flush wins over en and discards the sample.
   always_comb begin
      state_n = state;
      bit_n   = cur_bit;
      cnt_n   = cnt;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else if (en) begin
         if (state == IDLE) begin
            state_n = RUN;
            bit_n   = x;
            cnt_n   = CNT_W'(1);
         end else if (x == cur_bit && cnt != MAX) begin
            cnt_n   = cnt + 1'b1;
         end else begin
            bit_n   = x;
            cnt_n   = CNT_W'(1);
         end
      end
   end

   // Close the open run on flush, bit change or saturation.
   always_comb begin
      push     = 1'b0;
      push_bit = cur_bit;
      push_len = cnt;
      if (state == RUN) begin
         if (flush)
            push = 1'b1;
         else if (en && (x != cur_bit || cnt == MAX))
            push = 1'b1;
      end
   end

   assign out_valid = (count != '0);
   assign out_count = count;
   assign full      = (count == OW'(DEPTH));
   assign pop       = out_valid & out_ready;
   assign acc       = push & (~full | pop);
   assign rd_n      = pop ? rd_ptr + 1'b1 : rd_ptr;

   // Occupancy after this edge; a push into a full FIFO only lands with a pop.
   always_comb begin
      count_n = count;
      if (acc && !pop)
         count_n = count + 1'b1;
      else if (pop && !acc)
         count_n = count - 1'b1;
   end

   // Next head: the entry being written if it becomes the head, else storage.
   always_comb begin
      head_n = mem[rd_n];
      if (acc && rd_n == wr_ptr)
         head_n = {push_bit, push_len};
   end

   // Entry storage; needs no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (acc)
         mem[wr_ptr] <= {push_bit, push_len};
   end

   // Pointers, occupancy, registered head and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         out_bit <= 1'b0;
         out_len <= '0;
         ovf     <= 1'b0;
      end else begin
         rd_ptr <= rd_n;
         count  <= count_n;
         if (acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (push && full && !pop)
            ovf <= 1'b1;
         if (count_n != '0)
            {out_bit, out_len} <= head_n;
      end
   end

endmodule

// File: tb/tb_run_length_packer.sv
// tb_run_length_packer: directed scoreboard bench for run_length_packer
// with an 8-bit-length instance and a 3-bit-length instance.
module tb_run_length_packer;

   logic       clk, rst, x, en, flush;
   logic       rdy8, rdy3;
   logic       v8, b8, o8, v3, b3, o3;
   logic [7:0] l8;
   logic [2:0] l3, c8, c3;

   int tests = 0;
   int fails = 0;
   int maxc  = 0;
   bit mon8  = 0;
   bit mon3  = 0;
   bit trk   = 0;

   logic [8:0] q8[$];
   logic [8:0] q3[$];

   run_length_packer #(.CNT_W(8), .DEPTH(4)) dut8 (
      .clk(clk), .rst(rst), .x(x), .en(en), .flush(flush),
      .out_valid(v8), .out_ready(rdy8), .out_bit(b8),
      .out_len(l8), .out_count(c8), .ovf(o8)
   );

   run_length_packer #(.CNT_W(3), .DEPTH(4)) dut3 (
      .clk(clk), .rst(rst), .x(x), .en(en), .flush(flush),
      .out_valid(v3), .out_ready(rdy3), .out_bit(b3),
      .out_len(l3), .out_count(c3), .ovf(o3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic xv, input logic ev, input logic fv);
      x = xv;
      en = ev;
      flush = fv;
      tick();
   endtask

   task automatic do_reset();
      x = 0;
      en = 0;
      flush = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
      q8.delete();
      q3.delete();
   endtask

   // Scoreboard: compare the head each time it is about to be popped.
   always @(negedge clk) begin
      if (mon8 && !rst && v8 && rdy8) begin
         if (q8.size() == 0)
            chk("unexpected8", {23'd0, b8, l8}, 32'h1ff);
         else
            chk("head8", {23'd0, b8, l8}, {23'd0, q8.pop_front()});
      end
      if (mon3 && !rst && v3 && rdy3) begin
         if (q3.size() == 0)
            chk("unexpected3", {23'd0, b3, 5'd0, l3}, 32'h1ff);
         else
            chk("head3", {23'd0, b3, 5'd0, l3}, {23'd0, q3.pop_front()});
      end
      if (trk && int'(c8) > maxc)
         maxc = int'(c8);
   end

   initial begin
      clk = 0;
      rst = 1;
      x = 0;
      en = 0;
      flush = 0;
      rdy8 = 1;
      rdy3 = 1;
      #2;
      chk("rst_valid", {31'd0, v8}, 0);
      chk("rst_bit", {31'd0, b8}, 0);
      chk("rst_len", {24'd0, l8}, 0);
      chk("rst_count", {29'd0, c8}, 0);
      chk("rst_ovf", {31'd0, o8}, 0);
      do_reset();

      // Basic encode
      mon8 = 1;
      trk = 1;
      maxc = 0;
      q8.push_back({1'b0, 8'd1});
      q8.push_back({1'b1, 8'd6});
      q8.push_back({1'b0, 8'd3});
      drive(0, 1, 0);
      for (int i = 0; i < 6; i++) drive(1, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0);
      drive(0, 1, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 0);
      trk = 0;
      chk("basic_drained", q8.size(), 0);
      chk("basic_maxcnt", maxc, 1);
      chk("basic_count", {29'd0, c8}, 0);

      // Saturation on the 3-bit instance
      do_reset();
      mon8 = 0;
      mon3 = 1;
      q3.push_back({1'b1, 8'd7});
      q3.push_back({1'b1, 8'd3});
      q3.push_back({1'b0, 8'd1});
      for (int i = 0; i < 10; i++) drive(1, 1, 0);
      drive(0, 1, 0);
      drive(0, 1, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0);
      chk("sat_drained", q3.size(), 0);
      chk("sat_ovf", {31'd0, o3}, 0);
      mon3 = 0;

      // Backpressure and overflow
      do_reset();
      mon8 = 1;
      rdy8 = 0;
      for (int i = 0; i < 6; i++) drive(i[0], 1, 0);
      chk("bp_count", {29'd0, c8}, 4);
      chk("bp_ovf", {31'd0, o8}, 1);
      chk("bp_head", {23'd0, v8, b8, l8}, {23'd0, 1'b1, 1'b0, 8'd1});
      q8.push_back({1'b0, 8'd1});
      q8.push_back({1'b1, 8'd1});
      q8.push_back({1'b0, 8'd1});
      q8.push_back({1'b1, 8'd1});
      rdy8 = 1;
      for (int i = 0; i < 5; i++) drive(0, 0, 0);
      chk("bp_drained", q8.size(), 0);
      chk("bp_empty", {31'd0, v8}, 0);
      chk("bp_ovf_sticky", {31'd0, o8}, 1);
      q8.push_back({1'b1, 8'd1});
      drive(0, 0, 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0);
      chk("bp_open_run", q8.size(), 0);

      // Full FIFO with a simultaneous pop and push
      do_reset();
      rdy8 = 0;
      for (int i = 0; i < 5; i++) drive(i[0], 1, 0);
      chk("fp_full", {29'd0, c8}, 4);
      for (int i = 0; i < 4; i++) q8.push_back({i[0], 8'd1});
      q8.push_back({1'b0, 8'd1});
      rdy8 = 1;
      drive(1, 1, 0);
      chk("fp_count", {29'd0, c8}, 4);
      chk("fp_ovf", {31'd0, o8}, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0);
      chk("fp_drained", q8.size(), 0);
      chk("fp_empty", {31'd0, v8}, 0);

      // en gating and flush priority
      do_reset();
      q8.push_back({1'b1, 8'd5});
      for (int i = 0; i < 3; i++) drive(1, 1, 0);
      for (int i = 0; i < 2; i++) drive(0, 0, 0);
      for (int i = 0; i < 2; i++) drive(1, 1, 0);
      drive(0, 1, 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0);
      chk("en_drained", q8.size(), 0);
      drive(0, 0, 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0);
      chk("en_idle_flush", {29'd0, c8}, 0);
      chk("en_idle_valid", {31'd0, v8}, 0);

      // Asynchronous reset mid-run
      do_reset();
      rdy8 = 0;
      drive(0, 1, 0);
      drive(1, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0);
      chk("ar_count_pre", {29'd0, c8}, 2);
      #2;
      rst = 1;
      #1;
      chk("ar_valid", {31'd0, v8}, 0);
      chk("ar_count", {29'd0, c8}, 0);
      chk("ar_ovf", {31'd0, o8}, 0);
      q8.delete();
      x = 0;
      en = 0;
      tick();
      rst = 0;
      rdy8 = 1;
      q8.push_back({1'b1, 8'd1});
      drive(1, 1, 0);
      drive(0, 0, 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0);
      chk("ar_restart", q8.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/run_length_packer.md
Name: run_length_packer

Overview:
- Downstream stage of the last-3-sample majority detector.
- Consumes the detector's 1-bit per-clock output `y` and encodes it into runs, each a (bit value, run length) pair.
- Buffers completed runs in a small FIFO drained through a valid/ready handshake, so a slow consumer does not have to track every clock.
- Includes saturation, flush and overflow reporting.

Parameters:
- CNT_W, 8, width of the run-length field; maximum run length MAX = 2^CNT_W - 1.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- x  input  1  majority-filtered bit stream (detector output `y`).
- en  input  1  sample qualifier; x is counted only in cycles with en=1.
- flush  input  1  close the run in progress and return to IDLE.
- out_valid  output  1  FIFO non-empty; head entry is presented.
- out_ready  input  1  consumer accepts the head entry when out_valid=1.
- out_bit  output  1  bit value of the head run.
- out_len  output  CNT_W  length of the head run, 1..MAX.
- out_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- ovf  output  1  sticky flag: a completed run was dropped.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, cur_bit=0, cnt=0, FIFO empty, out_valid=0, out_bit=0, out_len=0, out_count=0, ovf=0.
  - Reset mid-run discards the partial run and all buffered entries.
- FSM states: IDLE (no run open) and RUN (cur_bit/cnt hold the open run).
- IDLE, en=1, flush=0: cur_bit<=x, cnt<=1, go to RUN.
- RUN, en=1, flush=0:
  - x==cur_bit, cnt<MAX: cnt<=cnt+1.
  - x==cur_bit, cnt==MAX: push {cur_bit, MAX}; cnt<=1; cur_bit unchanged (saturated runs split).
  - x!=cur_bit: push {cur_bit, cnt}; cur_bit<=x; cnt<=1.
- en=0, flush=0: no change to the run state; the FIFO still drains.
- flush=1 has priority over en; the sample in that cycle is discarded.
  - In RUN: push {cur_bit, cnt}, go to IDLE.
  - In IDLE: no-op.
- FIFO:
  - out_bit/out_len are registered head outputs, valid whenever out_valid=1.
  - pop = out_valid & out_ready.
  - Latency: a run closed at edge N is visible on out_valid/out_bit/out_len after edge N if the FIFO was empty. There is no combinational path from x to the outputs.
  - While out_valid=1 and out_ready=0, out_bit/out_len are held stable.
  - Simultaneous push and pop when full: both take effect; the push is accepted and occupancy stays DEPTH.
  - Simultaneous push and pop when empty is impossible (pop requires out_valid=1).
  - Push when full with no pop: entry dropped, ovf<=1, occupancy unchanged. ovf is cleared only by rst.
  - When the FIFO empties: out_valid=0; out_bit/out_len keep their last values (don't-care).
- out_count is always in the range 0..DEPTH; read/write pointers wrap modulo DEPTH.
- A pushed run length is never 0.

Test Plan:
- Basic encode:
  - Stimulus: CNT_W=8, DEPTH=4, out_ready=1, en=1, x = 0,1,1,1,1,1,1,0,0,0, then flush=1 for one cycle.
  - Response: entries (0,1), (1,6), (0,3) in order; out_count never exceeds 1; state IDLE after flush.
- Saturation:
  - Stimulus: CNT_W=3 (MAX=7), x = ten 1s then a 0, out_ready=1.
  - Response: (1,7) then (1,3); open run is (0,1).
- Backpressure/overflow:
  - Stimulus: DEPTH=4, out_ready=0, x alternating 0,1,0,1,0,1 with en=1.
  - Response: 5 runs closed; out_count=4; ovf=1; head=(0,1). Draining yields (0,1),(1,1),(0,1),(1,1), then out_valid=0; ovf stays 1.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 in the same cycle a run closes.
  - Response: out_count stays 4; ovf stays 0; the new entry appears after the 4 older ones.
- en gating and flush priority:
  - Stimulus: x=1 for 3 en cycles, 2 cycles en=0 with x=0, 2 more en cycles x=1, then flush with en=1 and x=0.
  - Response: single entry (1,5); no new run opened.
- Async reset mid-run:
  - Stimulus: assert rst between clock edges with 2 entries buffered and cnt=3.
  - Response: out_valid=0, out_count=0, ovf=0 immediately, before the next edge; next run after release starts at length 1.
